// File: rtl/hamm_rr_arbiter.sv
// hamm_rr_arbiter: round-robin arbiter that shares one 32-bit popcount
// datapath among four requesters and holds each result until it is consumed.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester valid (held with its data until granted)
//   req_data     flattened request words, requester i on [32i+31:32i]
//   gnt          one-hot combinational grant; transfer on req[i] & gnt[i]
//   res_valid    result available (held until res_ready)
//   res_id       requester index owning the result
//   res_count    popcount of the accepted word (0..32)
//   res_ready    consumer accept; handshake on res_valid & res_ready
//   busy         high whenever the sequencer is not idle
module hamm_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*W-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic                 res_valid,
  output logic [1:0]           res_id,
  output logic [7:0]           res_count,
  input  logic                 res_ready,
  output logic                 busy
);

  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [W-1:0]     op_data;
  logic [ID_W-1:0]  op_id;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic             xfer;
  logic [CNT_W-1:0] hamm_sum;

  // Rotating priority search: first set request at or above ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      cand = ptr + ID_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // A grant exists only while idle; rst_n gating keeps gnt low during reset.
  assign xfer = (state == IDLE) && win_found;
  assign gnt  = (xfer && rst_n) ? (N_REQ'(1) << win_id) : '0;
  assign busy = (state != IDLE);

  // HAMM_32bit: single combinational popcount stage between op_data and res_count.
  always_comb begin
    hamm_sum = '0;
    for (int i = 0; i < int'(W); i++) begin
      hamm_sum = hamm_sum + CNT_W'(op_data[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, pointer advance and result holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      op_data   <= '0;
      op_id     <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_count <= '0;
    end else begin
      if (xfer) begin
        op_data <= req_data[win_id*W +: W];
        op_id   <= win_id;
        ptr     <= win_id + ID_W'(1);
      end
      if (state == CALC) begin
        res_count <= hamm_sum;
        res_id    <= op_id;
        res_valid <= 1'b1;
      end
      if (state == RESP && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
